// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared types and defaults for the ping-pong frame buffer controller.
package pingpong_pkg;

  // Occupancy of one frame buffer over a fill / scan-out cycle.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } buf_state_t;

  localparam int unsigned DEPTH_DEFAULT = 10000;
  localparam int unsigned AW_DEFAULT    = 20;
  localparam int unsigned DW_DEFAULT    = 32;

  // A buffer may take host pixels until its last address has been written.
  function automatic logic is_writable(input buf_state_t s);
    return (s == EMPTY) || (s == FILLING);
  endfunction

  // A buffer may be scanned out once completely written and until drained.
  function automatic logic is_readable(input buf_state_t s);
    return (s == FULL) || (s == DRAINING);
  endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_fsm.sv
// Occupancy tracker for one frame buffer: EMPTY -> FILLING -> FULL -> DRAINING.
module buf_state_fsm
  import pingpong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_claim,
  input  logic       wr_last,
  input  logic       rd_claim,
  input  logic       rd_last,
  output buf_state_t state,
  output logic       empty
);

  buf_state_t state_q, state_d;

  // State register; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance on accepted writes/reads, finish on the last address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        // A one-pixel buffer completes on its first write.
        if (wr_claim) state_d = wr_last ? FULL : FILLING;
      end
      FILLING: begin
        if (wr_claim && wr_last) state_d = FULL;
      end
      FULL: begin
        if (rd_claim) state_d = rd_last ? EMPTY : DRAINING;
      end
      DRAINING: begin
        if (rd_claim && rd_last) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign state = state_q;
  assign empty = is_writable(state_q);

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer sequencer: host fills one buffer while the display
// scans out the other; owns all write/read/address controls of both buffers.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic          rd_sel,
  output logic          frame_done,
  output logic          underrun,
  output logic          WE0,
  output logic          WE1,
  output logic          RE0,
  output logic          RE1,
  output logic [AW-1:0] Addr0,
  output logic [AW-1:0] Addr1,
  output logic [DW-1:0] WData,
  output logic          Buf0Empty,
  output logic          Buf1Empty
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Writer and reader pointers / address counters.
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;

  // Registered display-side status.
  logic rd_valid_q, rd_valid_d;
  logic rd_sel_q, rd_sel_d;
  logic frame_done_q, frame_done_d;
  logic underrun_q, underrun_d;

  buf_state_t state0, state1;
  logic       empty0, empty1;
  buf_state_t wstate, rstate;

  logic wr_acc, rd_acc, readable;
  logic w_last, r_last;

  assign wstate   = wsel_q ? state1 : state0;
  assign rstate   = rsel_q ? state1 : state0;
  assign wr_ready = is_writable(wstate);
  assign readable = is_readable(rstate);
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_acc   = rd_req & readable;
  assign w_last   = (waddr_q == LAST_ADDR);
  assign r_last   = (raddr_q == LAST_ADDR);

  buf_state_fsm u_buf0_fsm (
    .clk      (clk),
    .reset    (reset),
    .wr_claim (wr_acc & ~wsel_q),
    .wr_last  (w_last),
    .rd_claim (rd_acc & ~rsel_q),
    .rd_last  (r_last),
    .state    (state0),
    .empty    (empty0)
  );

  buf_state_fsm u_buf1_fsm (
    .clk      (clk),
    .reset    (reset),
    .wr_claim (wr_acc & wsel_q),
    .wr_last  (w_last),
    .rd_claim (rd_acc & rsel_q),
    .rd_last  (r_last),
    .state    (state1),
    .empty    (empty1)
  );

  assign Buf0Empty = empty0;
  assign Buf1Empty = empty1;

  // Writer pointer: step per accepted pixel, wrap and swap buffers at the end.
  always_comb begin
    waddr_d = waddr_q;
    wsel_d  = wsel_q;
    if (wr_acc) begin
      if (w_last) begin
        waddr_d = '0;
        wsel_d  = ~wsel_q;
      end else begin
        waddr_d = waddr_q + AW'(1);
      end
    end
  end

  // Reader pointer plus next-cycle display status (valid, select, end-of-frame, underrun).
  always_comb begin
    raddr_d      = raddr_q;
    rsel_d       = rsel_q;
    rd_valid_d   = rd_acc;
    rd_sel_d     = rd_acc & rsel_q;
    frame_done_d = rd_acc & r_last;
    underrun_d   = rd_req & ~readable;
    if (rd_acc) begin
      if (r_last) begin
        raddr_d = '0;
        rsel_d  = ~rsel_q;
      end else begin
        raddr_d = raddr_q + AW'(1);
      end
    end
  end

  // Pointer, counter and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      rd_valid_q   <= rd_valid_d;
      rd_sel_q     <= rd_sel_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_sel     = rd_sel_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // Buffer strobes and address mux; an accepting writer has priority on its
  // buffer, otherwise the reader's counter is presented, otherwise zero.
  always_comb begin
    WE0   = 1'b0;
    WE1   = 1'b0;
    RE0   = 1'b0;
    RE1   = 1'b0;
    Addr0 = '0;
    Addr1 = '0;
    WData = '0;
    if (wr_acc) begin
      WData = wr_data;
      if (wsel_q) WE1 = 1'b1;
      else        WE0 = 1'b1;
    end
    if (rd_acc) begin
      if (rsel_q) RE1 = 1'b1;
      else        RE0 = 1'b1;
    end
    if (wr_acc && !wsel_q) Addr0 = waddr_q;
    else if (!rsel_q)      Addr0 = raddr_q;
    if (wr_acc && wsel_q)  Addr1 = waddr_q;
    else if (rsel_q)       Addr1 = raddr_q;
  end

  // Writable and readable states are disjoint, so both sides can never
  // act on the same buffer in one cycle.
  a_exclusive_owner: assert property (
    @(posedge clk) disable iff (!reset)
    !(wr_acc && rd_acc && (wsel_q == rsel_q))
  );

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with a pixel scoreboard and buffer models.
module tb_pingpong_buf_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_valid;
  logic          rd_sel;
  logic          frame_done;
  logic          underrun;
  logic          WE0, WE1, RE0, RE1;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] WData;
  logic          Buf0Empty, Buf1Empty;

  always #5 clk = ~clk;

  pingpong_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_sel     (rd_sel),
    .frame_done (frame_done),
    .underrun   (underrun),
    .WE0        (WE0),
    .WE1        (WE1),
    .RE0        (RE0),
    .RE1        (RE1),
    .Addr0      (Addr0),
    .Addr1      (Addr1),
    .WData      (WData),
    .Buf0Empty  (Buf0Empty),
    .Buf1Empty  (Buf1Empty)
  );

  // Models of the two frame buffers: synchronous write, one-cycle read.
  logic [23:0] mem0 [DEPTH];
  logic [23:0] mem1 [DEPTH];
  logic [23:0] rdata0, rdata1;

  always @(posedge clk) begin
    if (WE0) mem0[Addr0[1:0]] <= WData[23:0];
    if (WE1) mem1[Addr1[1:0]] <= WData[23:0];
    if (RE0) rdata0 <= mem0[Addr0[1:0]];
    if (RE1) rdata1 <= mem1[Addr1[1:0]];
  end

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned fd_cnt = 0;
  int unsigned ur_cnt = 0;
  logic [23:0] sbq [$];

  logic          o_we0, o_we1, o_re0, o_re1, o_rdy;
  logic [AW-1:0] o_a0, o_a1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample combinational outputs mid-cycle, score
  // any pixel delivered by the previous edge, record accepted writes.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic [23:0] e;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    @(negedge clk);
    o_we0 = WE0; o_we1 = WE1; o_re0 = RE0; o_re1 = RE1;
    o_a0  = Addr0; o_a1 = Addr1; o_rdy = wr_ready;
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (rd_valid) begin
      chk("sb_has_entry", (sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rd_pixel", rd_sel ? rdata1 : rdata0, e);
      end
    end
    if (wv && wr_ready) sbq.push_back(wd[23:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    fd_cnt = 0;
    ur_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_req = 1'b0;
    do_reset();

    // Reset values
    chk("rst_strobes", {WE0, WE1, RE0, RE1}, 4'b0000);
    chk("rst_addr0", Addr0, 0);
    chk("rst_addr1", Addr1, 0);
    chk("rst_wdata", WData, 0);
    chk("rst_rdside", {rd_valid, rd_sel, frame_done, underrun}, 4'b0000);
    chk("rst_empty_ready", {Buf0Empty, Buf1Empty, wr_ready}, 3'b111);

    // Read request with nothing readable
    step(1'b0, '0, 1'b1);
    chk("ur_no_re", {o_re0, o_re1}, 2'b00);
    chk("ur_pulse", underrun, 1);
    chk("ur_no_valid", rd_valid, 0);
    step(1'b0, '0, 1'b0);
    chk("ur_one_cycle", underrun, 0);

    // Fill buffer 0
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h00AABBC0 + 32'(i), 1'b0);
      chk("w0_we", {o_we0, o_we1}, 2'b10);
      chk("w0_addr", o_a0, 32'(i));
    end
    chk("w0_flags", {Buf0Empty, Buf1Empty}, 2'b01);
    chk("w0_ready_next_buf", wr_ready, 1);

    // Drain buffer 0; the earlier underrun must not have moved raddr
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      chk("r0_re", {o_re0, o_re1}, 2'b10);
      chk("r0_addr", o_a0, 32'(i));
      chk("r0_valid_sel", {rd_valid, rd_sel}, 2'b10);
      chk("r0_frame_done", frame_done, (i == 3));
      chk("r0_buf0empty", Buf0Empty, (i == 3));
    end
    step(1'b0, '0, 1'b0);
    chk("r0_idle", {rd_valid, frame_done}, 2'b00);
    chk("r0_fd_cnt", fd_cnt, 1);

    // Fill both buffers, then the ninth write stalls until buffer 0 drains
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h00110000 + 32'(i), 1'b0);
      chk("f8_we", {o_we0, o_we1}, (i < 4) ? 2'b10 : 2'b01);
      chk("f8_addr", (i < 4) ? o_a0 : o_a1, 32'(i % 4));
    end
    chk("f8_both_full", {Buf0Empty, Buf1Empty}, 2'b00);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h00119999, 1'b0);
      chk("f8_stall", {o_rdy, o_we0, o_we1}, 3'b000);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h00119999, 1'b1);
      chk("f8_stall_rd", {o_rdy, o_we0, o_re0}, 3'b001);
      chk("f8_rd_addr", o_a0, 32'(k));
    end
    step(1'b1, 32'h00119999, 1'b0);
    chk("f8_resume", {o_rdy, o_we0, o_we1}, 3'b110);
    chk("f8_resume_addr", o_a0, 0);

    // Reset mid-fill of buffer 1 (waddr = 2)
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h00220000 + 32'(i), 1'b0);
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mr_flags", {Buf0Empty, Buf1Empty, wr_ready}, 3'b111);
    chk("mr_outs", {WE0, WE1, RE0, RE1, rd_valid, rd_sel, frame_done, underrun}, 8'h00);
    chk("mr_addr", {Addr0, Addr1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    step(1'b0, '0, 1'b1);
    chk("mr_nothing_readable", underrun, 1);
    step(1'b1, 32'h00223333, 1'b0);
    chk("mr_first_write", {o_we0, o_we1}, 2'b10);
    chk("mr_first_addr", o_a0, 0);

    // Concurrent streaming: 4 frames written, 4 frames read
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b1, 32'h00C00000 + 32'(n), 1'b0);
    for (int n = 4; n < 16; n++) begin
      step(1'b1, 32'h00C00000 + 32'(n * 7), 1'b1);
      chk("st_no_stall", o_rdy, 1);
      chk("st_read", o_re0 | o_re1, 1);
      chk("st_split", {o_we0, o_we1}, {o_re1, o_re0});
    end
    for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("st_frames", fd_cnt, 4);
    chk("st_no_underrun", ur_cnt, 0);
    chk("st_sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
